ctx_mem_arbiter: RTL
====================

CTX_MEM_ARBITER -- requirements
Module: ctx_mem_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, context-write FIFO entries (power of two, >=2).
REQ-002 Parameter STARVE_LIMIT, default 8, consecutive lost cycles before the context path gains priority (1..255).
REQ-003 The block SHALL have one clock and an asynchronous active-low reset:
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
REQ-004 Core data port (OBI-like) SHALL be:
- core_req_i  in  1  core request.
- core_gnt_o  out  1  core request accepted.
- core_rvalid_o  out  1  core response valid.
- core_we_i  in  1  write enable.
- core_be_i  in  4  byte enables.
- core_addr_i  in  32  address.
- core_wdata_i  in  32  write data.
- core_rdata_o  out  32  read data.
REQ-005 Context-write port from the RTOS unit SHALL be:
- ctx_wr_valid_i  in  1  write offered.
- ctx_wr_ready_o  out  1  FIFO can accept.
- ctx_wr_addr_i  in  32  word address.
- ctx_wr_data_i  in  32  data.
REQ-006 Memory port SHALL be:
- mem_req_o  out  1, mem_gnt_i  in  1, mem_rvalid_i  in  1.
- mem_we_o  out  1, mem_be_o  out  4, mem_addr_o  out  32, mem_wdata_o  out  32, mem_rdata_i  in  32.
REQ-007 Status SHALL be:
- ctx_fifo_level_o  out  clog2(FIFO_DEPTH)+1  entries held.
- protocol_err_o  out  1  sticky unexpected-rvalid flag.

Function
REQ-008 ctx_wr_ready_o SHALL equal "FIFO not full"; push occurs when ctx_wr_valid_i && ctx_wr_ready_o; no bypass, so a full FIFO refuses a push even in a pop cycle.
REQ-009 The FIFO SHALL pop exactly when a context transaction receives mem_gnt_i; pointers wrap modulo FIFO_DEPTH; level SHALL update +1, -1, or 0 (simultaneous push and pop).
REQ-010 States SHALL be IDLE, HOLD_CORE, HOLD_CTX, RSP_CORE, RSP_CTX; at most one memory transaction outstanding.
REQ-011 In IDLE, source selection SHALL be combinational: CTX if FIFO non-empty and (starve count == STARVE_LIMIT or !core_req_i); else CORE if core_req_i; else none, with mem_req_o=0.
REQ-012 In IDLE with a source selected, mem_req_o=1 that cycle. With mem_gnt_i=1 the next state SHALL be RSP_x; otherwise HOLD_x.
REQ-013 In HOLD_x, mem_req_o SHALL stay 1 and address, data, we and be SHALL stay stable from the same source until mem_gnt_i, then go to RSP_x; no re-arbitration.
REQ-014 In RSP_x, mem_req_o SHALL be 0; on mem_rvalid_i go to IDLE next cycle, so a new request issues no earlier than the cycle after rvalid.
REQ-015 CORE selection SHALL drive core_* request fields to mem_*; core_gnt_o = mem_gnt_i while CORE is selected and mem_req_o=1, else 0.
REQ-016 CTX selection SHALL drive mem_we_o=1, mem_be_o=4'hF, and the FIFO head address/data; core_gnt_o=0.
REQ-017 core_rvalid_o SHALL equal mem_rvalid_i in RSP_CORE, else 0; core_rdata_o = mem_rdata_i always; context responses SHALL be consumed silently.
REQ-018 The starve counter, 8 bits, SHALL increment, saturating at STARVE_LIMIT, each cycle the FIFO is non-empty and no context grant occurs; it SHALL clear on a context grant or when the FIFO is empty.
REQ-019 mem_rvalid_i outside RSP states SHALL set protocol_err_o, held until reset, and SHALL otherwise be ignored.
REQ-020 Idle outputs (mem_addr_o, mem_wdata_o, mem_be_o, mem_we_o) SHALL be 0 when no source is selected.

Reset
REQ-021 On rst_ni=0, asynchronously: state IDLE, FIFO empty (level 0), starve count 0, protocol_err_o 0, mem_req_o 0, core_gnt_o 0, core_rvalid_o 0, ctx_wr_ready_o 1 once in reset.
REQ-022 Reset mid-transaction SHALL drop any held or outstanding transaction and FIFO contents without a core response; the first cycle after release behaves as IDLE.

Verification
REQ-023 Bench SHALL cover these directed scenarios:
- Core read 0x100, gnt same cycle, rvalid next cycle with 0xCAFE0001 -> core_gnt_o in cycle 0, core_rvalid_o=1 with rdata 0xCAFE0001 in cycle 1, IDLE in cycle 2.
- 5 context writes back-to-back, memory stalled, FIFO_DEPTH=4 -> ready drops after 4th push, level=4, 5th held until first pop.
- Core request held continuously while FIFO holds 1 entry, STARVE_LIMIT=8, gnt immediate -> context write granted once the counter reaches 8, before the next core grant.
- gnt withheld 3 cycles in HOLD_CTX with a new push -> mem_addr_o/mem_wdata_o stable; level goes 1->2, then 1 after grant.
- Spurious mem_rvalid_i in IDLE -> protocol_err_o=1 sticky; no core_rvalid_o.
- rst_ni pulse during RSP_CORE with 2 FIFO entries -> all outputs reset values, level 0, no core_rvalid_o after release.

Source files
------------

// File: rtl/ctx_mem_arbiter.sv
// ----------------------------------------------------------------------------
// ctx_mem_arbiter
//   Shares one OBI-like memory port between the core data port and a posted
//   context-write stream from the RTOS unit. Context writes are buffered in a
//   small FIFO. They normally yield to the core, but they take priority once
//   they have waited STARVE_LIMIT cycles. Only one memory transaction is
//   outstanding at a time. Context write responses are absorbed here.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   core_*                   core request/grant/response (OBI-like)
//   ctx_wr_*                 context write offer (valid/ready)
//   mem_*                    downstream memory port (OBI-like)
//   ctx_fifo_level_o         number of buffered context writes
//   protocol_err_o           sticky flag: mem_rvalid_i seen with nothing pending
// ----------------------------------------------------------------------------
module ctx_mem_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    // core data port
    input  logic                          core_req_i,
    output logic                          core_gnt_o,
    output logic                          core_rvalid_o,
    input  logic                          core_we_i,
    input  logic [3:0]                    core_be_i,
    input  logic [31:0]                   core_addr_i,
    input  logic [31:0]                   core_wdata_i,
    output logic [31:0]                   core_rdata_o,
    // context write port
    input  logic                          ctx_wr_valid_i,
    output logic                          ctx_wr_ready_o,
    input  logic [31:0]                   ctx_wr_addr_i,
    input  logic [31:0]                   ctx_wr_data_i,
    // memory port
    output logic                          mem_req_o,
    input  logic                          mem_gnt_i,
    input  logic                          mem_rvalid_i,
    output logic                          mem_we_o,
    output logic [3:0]                    mem_be_o,
    output logic [31:0]                   mem_addr_o,
    output logic [31:0]                   mem_wdata_o,
    input  logic [31:0]                   mem_rdata_i,
    // status
    output logic [$clog2(FIFO_DEPTH):0]   ctx_fifo_level_o,
    output logic                          protocol_err_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_HOLD_CORE = 3'd1;
    localparam logic [2:0] ST_HOLD_CTX  = 3'd2;
    localparam logic [2:0] ST_RSP_CORE  = 3'd3;
    localparam logic [2:0] ST_RSP_CTX   = 3'd4;

    localparam logic [AW:0] LVL_FULL   = (AW+1)'(FIFO_DEPTH);
    localparam logic [7:0]  STARVE_MAX = 8'(STARVE_LIMIT);

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic [31:0]   r_fifo_addr [FIFO_DEPTH];
    logic [31:0]   r_fifo_data [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;
    logic [7:0]    r_starve;
    logic          r_perr;

    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_sel_core;
    logic          w_sel_ctx;
    logic          w_in_rsp;

    assign w_empty  = (r_level == '0);
    assign w_full   = (r_level == LVL_FULL);
    // No bypass: a full FIFO refuses even when the head is popping this cycle.
    assign w_push   = ctx_wr_valid_i && !w_full;
    assign w_in_rsp = (r_state == ST_RSP_CORE) || (r_state == ST_RSP_CTX);

    // Source selection: free arbitration only in IDLE; HOLD locks the source.
    always_comb begin
        w_sel_core = 1'b0;
        w_sel_ctx  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && ((r_starve == STARVE_MAX) || !core_req_i))
                    w_sel_ctx = 1'b1;
                else if (core_req_i)
                    w_sel_core = 1'b1;
            end
            ST_HOLD_CORE: w_sel_core = 1'b1;
            ST_HOLD_CTX:  w_sel_ctx  = 1'b1;
            default: ;
        endcase
    end

    // Memory request mux; fields are zero when nothing is selected.
    always_comb begin
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;
        if (w_sel_ctx) begin
            mem_we_o    = 1'b1;
            mem_be_o    = 4'hF;
            mem_addr_o  = r_fifo_addr[r_rptr];
            mem_wdata_o = r_fifo_data[r_rptr];
        end else if (w_sel_core) begin
            mem_we_o    = core_we_i;
            mem_be_o    = core_be_i;
            mem_addr_o  = core_addr_i;
            mem_wdata_o = core_wdata_i;
        end
    end

    assign mem_req_o        = w_sel_core || w_sel_ctx;
    assign core_gnt_o       = w_sel_core && mem_gnt_i;
    assign w_pop            = w_sel_ctx && mem_gnt_i;
    assign core_rvalid_o    = (r_state == ST_RSP_CORE) && mem_rvalid_i;
    assign core_rdata_o     = mem_rdata_i;
    assign ctx_wr_ready_o   = !w_full;
    assign ctx_fifo_level_o = r_level;
    assign protocol_err_o   = r_perr;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_HOLD_CORE, ST_HOLD_CTX: begin
                if (w_sel_ctx)
                    w_state_nxt = mem_gnt_i ? ST_RSP_CTX : ST_HOLD_CTX;
                else if (w_sel_core)
                    w_state_nxt = mem_gnt_i ? ST_RSP_CORE : ST_HOLD_CORE;
            end
            ST_RSP_CORE, ST_RSP_CTX: begin
                if (mem_rvalid_i)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= ST_IDLE;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_level  <= '0;
            r_starve <= 8'd0;
            r_perr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            // Counts cycles a buffered write has been waiting, saturating.
            if (w_empty || w_pop)
                r_starve <= 8'd0;
            else if (r_starve != STARVE_MAX)
                r_starve <= r_starve + 8'd1;
            if (mem_rvalid_i && !w_in_rsp)
                r_perr <= 1'b1;
        end
    end

    // FIFO storage needs no reset; the pointers and level define validity.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= ctx_wr_addr_i;
            r_fifo_data[r_wptr] <= ctx_wr_data_i;
        end
    end

endmodule
